// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and types for the serial word receiver
// Purpose: word width, receiver FSM state type and default parameter values.
// No ports.
package serial_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_LENGTH  = 4;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/serial_rx_shreg.sv
// rtl/serial_rx_shreg.sv - chunk assembly shift register with chunk counter
// Purpose: shifts LENGTH-bit chunks MSB-chunk-first into a WORD_W-bit register.
// Ports:
//   clkTx  in   receive clock
//   reset  in   asynchronous active-high reset
//   clear  in   synchronous clear of register and count
//   shift  in   accept din this cycle
//   din    in   LENGTH-bit chunk
//   word   out  word including the chunk being shifted this cycle
//   last   out  high when this cycle's shift completes the word
module serial_rx_shreg
    import serial_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH
) (
    input  logic              clkTx,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [LENGTH-1:0] din,
    output logic [WORD_W-1:0] word,
    output logic              last
);

    localparam int CHUNKS = WORD_W / LENGTH;
    localparam int CNT_W  = $clog2(CHUNKS + 1);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;
    logic [CNT_W-1:0]  count;

    // A full-width chunk simply replaces the register; otherwise shift left.
    generate
        if (LENGTH == WORD_W) begin : g_full
            assign shreg_next = din;
        end else begin : g_shift
            assign shreg_next = {shreg[WORD_W-LENGTH-1:0], din};
        end
    endgenerate

    // word is the look-ahead value so the parent can load it on the same
    // edge that samples the final chunk.
    assign word = shreg_next;
    assign last = shift && (count == CNT_W'(CHUNKS - 1));

    always_ff @(posedge clkTx or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            shreg <= '0;
            count <= '0;
        end else if (shift) begin
            shreg <= shreg_next;
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - chunked serial word receiver with read handshake
// Purpose: assembles 32/LENGTH chunks into a word after startRx, holds it
// in dout until acknowledged, flags overruns.
// Optional feature macro: SERIAL_RX_TIMEOUT_EN (idle timeout abort + timeoutErr).
// Ports:
//   clkTx       in   receive clock
//   reset       in   asynchronous active-high reset
//   startRx     in   arm reception of one word (accepted in IDLE only)
//   rxValid     in   din valid this cycle (sampled in RECV only)
//   din         in   LENGTH-bit chunk, MSB chunk first
//   rdAck       in   consumer has taken dout
//   dout        out  last assembled word
//   dataValid   out  dout holds an unread word
//   rxBusy      out  word assembly in progress
//   rxDone      out  one-cycle completion pulse
//   overrun     out  sticky: completed word replaced an unread word
//   timeoutErr  out  sticky: reception aborted on idle timeout (macro only)
module serial_receiver
    import serial_pkg::*;
#(
    parameter int LENGTH  = DEFAULT_LENGTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clkTx,
    input  logic              reset,
    input  logic              startRx,
    input  logic              rxValid,
    input  logic [LENGTH-1:0] din,
    input  logic              rdAck,
    output logic [WORD_W-1:0] dout,
    output logic              dataValid,
    output logic              rxBusy,
    output logic              rxDone,
`ifdef SERIAL_RX_TIMEOUT_EN
    output logic              overrun,
    output logic              timeoutErr
`else
    output logic              overrun
`endif
);

    generate
        if ((WORD_W % LENGTH) != 0 || TIMEOUT < 1) begin : g_bad_param
            $error("serial_receiver: LENGTH must divide 32 and TIMEOUT must be positive");
        end
    endgenerate

    rx_state_t         state;
    logic              shift;
    logic              clear;
    logic              last;
    logic [WORD_W-1:0] word;
    logic              start_ok;

    assign start_ok = (state == IDLE) && startRx;
    assign shift    = (state == RECV) && rxValid;

`ifdef SERIAL_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_hit;

    // Abort on the TIMEOUT-th consecutive cycle without a chunk.
    assign timeout_hit = (state == RECV) && !rxValid
                         && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign clear       = start_ok || timeout_hit;
`else
    assign clear       = start_ok;
`endif

    serial_rx_shreg #(
        .LENGTH (LENGTH)
    ) u_shreg (
        .clkTx (clkTx),
        .reset (reset),
        .clear (clear),
        .shift (shift),
        .din   (din),
        .word  (word),
        .last  (last)
    );

    always_ff @(posedge clkTx or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dout       <= '0;
            dataValid  <= 1'b0;
            rxBusy     <= 1'b0;
            rxDone     <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_TIMEOUT_EN
            timeoutErr <= 1'b0;
            idle_cnt   <= '0;
`endif
        end else begin
            rxDone <= 1'b0;

            // Output word handshake; an ack coinciding with completion
            // counts as consuming the old word, so no overrun then.
            if (last) begin
                dout      <= word;
                dataValid <= 1'b1;
                if (dataValid && !rdAck) begin
                    overrun <= 1'b1;
                end
            end else if (rdAck) begin
                dataValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (startRx) begin
                        state      <= RECV;
                        rxBusy     <= 1'b1;
                        overrun    <= 1'b0;
`ifdef SERIAL_RX_TIMEOUT_EN
                        timeoutErr <= 1'b0;
                        idle_cnt   <= '0;
`endif
                    end
                end
                RECV: begin
                    if (last) begin
                        state  <= IDLE;
                        rxBusy <= 1'b0;
                        rxDone <= 1'b1;
`ifdef SERIAL_RX_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        rxBusy     <= 1'b0;
                        timeoutErr <= 1'b1;
                    end else if (rxValid) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    rxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed self-checking bench for serial_receiver
module tb_serial_receiver;

    logic        clkTx = 1'b0;
    logic        reset = 1'b1;
    logic        startRx = 1'b0;
    logic        rxValid = 1'b0;
    logic [3:0]  din = 4'h0;
    logic        rdAck = 1'b0;
    logic [31:0] dout;
    logic        dataValid;
    logic        rxBusy;
    logic        rxDone;
    logic        overrun;
`ifdef SERIAL_RX_TIMEOUT_EN
    logic        timeoutErr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clkTx = ~clkTx;

    serial_receiver #(
        .LENGTH  (4),
        .TIMEOUT (64)
    ) dut (
        .clkTx      (clkTx),
        .reset      (reset),
        .startRx    (startRx),
        .rxValid    (rxValid),
        .din        (din),
        .rdAck      (rdAck),
        .dout       (dout),
        .dataValid  (dataValid),
        .rxBusy     (rxBusy),
        .rxDone     (rxDone),
`ifdef SERIAL_RX_TIMEOUT_EN
        .overrun    (overrun),
        .timeoutErr (timeoutErr)
`else
        .overrun    (overrun)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clkTx);
    endtask

    task automatic start_rx();
        startRx = 1'b1;
        tick();
        startRx = 1'b0;
    endtask

    // Sends 8 nibbles MSB first with 'gap' idle cycles between chunks.
    // ack_last raises rdAck together with the final chunk; poke_start
    // raises startRx together with chunk 3 (must be ignored in RECV).
    task automatic send_word(input logic [31:0] w, input int gap,
                             input bit ack_last, input bit poke_start);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 8; i++) begin
            din     = v[31-4*i -: 4];
            rxValid = 1'b1;
            rdAck   = ack_last && (i == 7);
            startRx = poke_start && (i == 3);
            tick();
            rxValid = 1'b0;
            rdAck   = 1'b0;
            startRx = 1'b0;
            if (i == 6) check("no_done_early", {31'b0, rxDone}, 32'd0);
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (g == gap - 1) check("busy_in_gap", {31'b0, rxBusy}, 32'd1);
                end
            end
        end
    endtask

    initial begin
        tick();
        check("rst_dout", dout, 32'h0);
        check("rst_flags", {28'b0, dataValid, rxBusy, rxDone, overrun}, 32'h0);
        reset = 1'b0;

        // rxValid in IDLE is ignored
        din = 4'hF; rxValid = 1'b1;
        repeat (3) tick();
        rxValid = 1'b0;
        check("idle_ignore_busy", {31'b0, rxBusy}, 32'd0);

        // back-to-back chunks
        start_rx();
        check("busy_after_start", {31'b0, rxBusy}, 32'd1);
        send_word(32'hDEADBEEF, 0, 1'b0, 1'b0);
        check("b2b_dout", dout, 32'hDEADBEEF);
        check("b2b_flags", {28'b0, dataValid, rxBusy, rxDone, overrun}, 32'b1010);
        tick();
        check("done_one_cycle", {31'b0, rxDone}, 32'd0);

        // ack clears dataValid; ack again has no effect
        rdAck = 1'b1; tick(); rdAck = 1'b0;
        check("ack_clears", {31'b0, dataValid}, 32'd0);
        rdAck = 1'b1; tick(); rdAck = 1'b0;
        check("ack_noop", {30'b0, dataValid, overrun}, 32'd0);

        // gapped chunks, plus startRx during RECV is ignored
        start_rx();
        send_word(32'hDEADBEEF, 3, 1'b0, 1'b1);
        check("gap_dout", dout, 32'hDEADBEEF);
        check("gap_flags", {28'b0, dataValid, rxBusy, rxDone, overrun}, 32'b1010);

        // overrun: unread word replaced
        rdAck = 1'b1; tick(); rdAck = 1'b0;
        start_rx();
        send_word(32'h12345678, 0, 1'b0, 1'b0);
        check("ovr_first", dout, 32'h12345678);
        start_rx();
        send_word(32'hCAFEF00D, 1, 1'b0, 1'b0);
        check("ovr_dout", dout, 32'hCAFEF00D);
        check("ovr_flags", {29'b0, dataValid, rxBusy, overrun}, 32'b101);

        // startRx clears overrun; ack at completion avoids a new overrun
        start_rx();
        check("ovr_cleared", {31'b0, overrun}, 32'd0);
        send_word(32'h0BADF00D, 0, 1'b1, 1'b0);
        check("ackdone_dout", dout, 32'h0BADF00D);
        check("ackdone_flags", {29'b0, dataValid, rxDone, overrun}, 32'b110);

        // asynchronous reset mid-word
        start_rx();
        for (int i = 0; i < 5; i++) begin
            din = 4'h7; rxValid = 1'b1; tick();
        end
        rxValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_dout", dout, 32'h0);
        check("arst_flags", {28'b0, dataValid, rxBusy, rxDone, overrun}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_done", {31'b0, rxDone}, 32'd0);
        start_rx();
        send_word(32'hA5A5A5A5, 0, 1'b0, 1'b0);
        check("fresh_dout", dout, 32'hA5A5A5A5);
        check("fresh_flags", {29'b0, dataValid, rxBusy, overrun}, 32'b100);

`ifdef SERIAL_RX_TIMEOUT_EN
        // 3 chunks then 64 idle cycles -> abort
        start_rx();
        for (int i = 0; i < 3; i++) begin
            din = 4'h3; rxValid = 1'b1; tick();
        end
        rxValid = 1'b0;
        repeat (63) tick();
        check("to_not_yet", {30'b0, timeoutErr, rxBusy}, 32'b01);
        tick();
        check("to_flags", {29'b0, timeoutErr, rxBusy, rxDone}, 32'b100);
        check("to_dout", dout, 32'hA5A5A5A5);
        check("to_valid", {31'b0, dataValid}, 32'd1);
        start_rx();
        check("to_cleared", {31'b0, timeoutErr}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter LENGTH, default 4: chunk width in bits; SHALL be one of 1, 2, 4, 8, 16, 32 so that it divides 32 exactly.
REQ-002 Parameter TIMEOUT, default 64: idle-cycle limit used only when SERIAL_RX_TIMEOUT_EN is defined.
REQ-003 clkTx  input  1  receive clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startRx  input  1  arms reception of one 32-bit word.
REQ-006 rxValid  input  1  din carries a valid chunk this cycle.
REQ-007 din  input  LENGTH  incoming chunk; chunks arrive MSB chunk first.
REQ-008 rdAck  input  1  consumer has taken dout.
REQ-009 dout  output  32  last assembled word.
REQ-010 dataValid  output  1  dout holds an unread word.
REQ-011 rxBusy  output  1  a word is being assembled.
REQ-012 rxDone  output  1  one-cycle pulse marking word completion.
REQ-013 overrun  output  1  sticky flag: a completed word replaced an unread word.
REQ-014 timeoutErr  output  1  sticky flag for abort on timeout; present only with SERIAL_RX_TIMEOUT_EN.

Function
REQ-015 FSM states SHALL be IDLE and RECV.
REQ-016 IDLE->RECV SHALL occur on a cycle with startRx=1; chunk count is cleared and rxBusy=1 from the next cycle.
REQ-017 rxValid in the startRx cycle SHALL be ignored; sampling starts in the first RECV cycle.
REQ-018 In RECV, each cycle with rxValid=1 SHALL shift the assembly register left by LENGTH, insert din in the LSBs, and increment the chunk count.
REQ-019 On the edge sampling chunk 32/LENGTH, the SHALL register the following together:
- dout is loaded with the assembled word;
- dataValid is set to 1;
- rxDone is 1 for exactly the next cycle;
- the state returns to IDLE and rxBusy goes to 0.
REQ-020 Latency: dout SHALL be valid in the cycle immediately after the last chunk is sampled.
REQ-021 startRx while in RECV SHALL be ignored; the count SHALL NOT restart.
REQ-022 rdAck with dataValid=1 SHALL clear dataValid on the next edge; rdAck with dataValid=0 SHALL have no effect.
REQ-023 If a word completes while dataValid=1 and rdAck=0, overrun SHALL be set, dout SHALL take the new word, and dataValid SHALL stay 1.
REQ-024 If rdAck coincides with word completion, the new word SHALL load, dataValid SHALL stay 1, and overrun SHALL NOT be set.
REQ-025 overrun SHALL clear only on reset or on startRx accepted in IDLE.
REQ-026 rxValid in IDLE SHALL be ignored.

Reset
REQ-027 Reset SHALL act immediately and asynchronously and SHALL force the following:
- state to IDLE;
- chunk count and assembly register to 0;
- dout to 32'h0;
- dataValid, rxBusy, rxDone, overrun and timeoutErr to 0.
REQ-028 Reset during RECV SHALL discard the partial word; no rxDone pulse SHALL be produced.

Configuration
REQ-029 Macro SERIAL_RX_TIMEOUT_EN defined:
- in RECV, a counter SHALL count consecutive cycles with rxValid=0;
- reaching TIMEOUT SHALL abort to IDLE, discard the partial word and set timeoutErr;
- dout and dataValid SHALL be left unchanged;
- timeoutErr SHALL clear on reset or on startRx accepted in IDLE.
REQ-030 Macro SERIAL_RX_TIMEOUT_EN undefined: no timeout counter, no timeoutErr port, and RECV SHALL wait indefinitely for chunks.

Structure
REQ-031 Package serial_pkg SHALL hold:
- the WORD_W=32 constant;
- the rx_state_t enum {IDLE, RECV};
- the default LENGTH and TIMEOUT constants.
REQ-032 The shift register plus chunk counter SHALL be the sub-module serial_rx_shreg, with ports clear, shift, din, word and last.

Verification
REQ-033 LENGTH=4; startRx; chunks D,E,A,D,B,E,E,F on 8 consecutive cycles -> dout=32'hDEADBEEF, one-cycle rxDone, dataValid=1, rxBusy=0.
REQ-034 Same word with rxValid gaps of 3 idle cycles between chunks -> identical dout; rxBusy=1 throughout the gaps.
REQ-035 Receive 32'h12345678, no rdAck, then receive 32'hCAFEF00D -> dout=32'hCAFEF00D, overrun=1; next startRx clears overrun.
REQ-036 rdAck asserted in the completion cycle of a second word -> dataValid stays 1, overrun=0.
REQ-037 Reset asserted after 5 of 8 chunks -> all outputs 0 immediately; a fresh startRx plus 8 chunks of 32'hA5A5A5A5 -> dout=32'hA5A5A5A5.
REQ-038 With SERIAL_RX_TIMEOUT_EN and TIMEOUT=64: 3 chunks then 64 idle cycles -> timeoutErr=1, state IDLE, dout unchanged, no rxDone.
